// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The next-PC selector encodings must match those produced by the control unit.
package fetch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_WAIT = 3'd2,
      ST_HOLD = 3'd3,
      ST_ERR  = 3'd4
   } fetch_state_e;

   localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
   localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
   localparam logic [1:0] PC_SRC_JAL    = 2'b10;
   localparam logic [1:0] PC_SRC_JALR   = 2'b11;

   // addi x0, x0, 0: harmless opcode for the control unit while nothing is held
   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

   // Instruction addresses must be word aligned
   function automatic logic is_misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory port: a valid/ready request channel carrying the fetch
// address and a valid-only response channel carrying the instruction word.
interface instr_fetch_unit_if;

   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;

   // The fetch unit issues requests and consumes responses
   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data
   );

   // The instruction memory accepts requests and returns data
   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data
   );

endinterface

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection. All adds wrap modulo 2^32; the jalr
// target has bit 0 cleared before the alignment check.
module next_pc_calc
   import fetch_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [1:0]  pc_src,
   input  logic        branch_taken,
   input  logic [31:0] imm,
   input  logic [31:0] jalr_base,
   output logic [31:0] next_pc,
   output logic        misaligned
);

   logic [31:0] seq_pc;
   logic [31:0] rel_pc;
   logic [31:0] jalr_pc;

   assign seq_pc  = pc + 32'd4;
   assign rel_pc  = pc + imm;
   assign jalr_pc = (jalr_base + imm) & ~32'h1;

   // Pick the target requested by the control stage
   always_comb begin
      next_pc = seq_pc;
      case (pc_src)
         PC_SRC_PLUS4:  next_pc = seq_pc;
         PC_SRC_BRANCH: next_pc = branch_taken ? rel_pc : seq_pc;
         PC_SRC_JAL:    next_pc = rel_pc;
         PC_SRC_JALR:   next_pc = jalr_pc;
         default:       next_pc = seq_pc;
      endcase
   end

   assign misaligned = is_misaligned(next_pc);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word at a time from a
// multi-cycle instruction memory and holds it for decode until retired.
// A misaligned jump target parks the unit in ERR until reset.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = fetch_pkg::RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst_n,
   instr_fetch_unit_if.master         imem,
   output logic [31:0]                instr,
   output logic                       instr_valid,
   output logic [31:0]                pc,
   output logic [31:0]                pc_plus4,
   input  logic                       advance,
   input  logic [1:0]                 pc_src,
   input  logic                       branch_taken,
   input  logic [31:0]                imm,
   input  logic [31:0]                jalr_base,
   output logic                       misalign_err
);

   fetch_state_e state_reg, state_next;
   logic [31:0]  pc_reg, pc_next;
   logic [31:0]  instr_reg, instr_next;
   logic [31:0]  target_pc;
   logic         target_misaligned;

   next_pc_calc u_next_pc_calc (
      .pc           (pc_reg),
      .pc_src       (pc_src),
      .branch_taken (branch_taken),
      .imm          (imm),
      .jalr_base    (jalr_base),
      .next_pc      (target_pc),
      .misaligned   (target_misaligned)
   );

   // State, PC and held instruction; reset abandons any in-flight request
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         pc_reg    <= RESET_PC;
         instr_reg <= NOP_INSTR;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         instr_reg <= instr_next;
      end
   end

   // Fetch sequencing: responses count only in WAIT, retires only in HOLD
   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      instr_next = instr_reg;
      case (state_reg)
         ST_IDLE: state_next = ST_REQ;
         ST_REQ: begin
            if (imem.imem_req_ready) begin
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (imem.imem_rsp_valid) begin
               instr_next = imem.imem_rsp_data;
               state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (advance) begin
               pc_next    = target_pc;
               instr_next = NOP_INSTR;
               state_next = target_misaligned ? ST_ERR : ST_REQ;
            end
         end
         ST_ERR:  state_next = ST_ERR;
         default: state_next = ST_IDLE;
      endcase
   end

   // Outputs decoded from state and registers only
   assign imem.imem_req_valid = (state_reg == ST_REQ);
   assign imem.imem_req_addr  = pc_reg;
   assign instr_valid         = (state_reg == ST_HOLD);
   assign misalign_err        = (state_reg == ST_ERR);
   assign instr               = instr_reg;
   assign pc                  = pc_reg;
   assign pc_plus4            = pc_reg + 32'd4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: expected fetch addresses are queued
// when a retire (or reset) is driven and popped when the request appears.
module tb_instr_fetch_unit;
   import fetch_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        advance;
   logic [1:0]  pc_src;
   logic        branch_taken;
   logic [31:0] imm;
   logic [31:0] jalr_base;
   logic        misalign_err;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          hs_cnt   = 0;
   logic [31:0] exp_q[$];

   instr_fetch_unit_if bus();

   instr_fetch_unit #(
      .RESET_PC  (RST_PC),
      .NOP_INSTR (NOP)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem         (bus),
      .instr        (instr),
      .instr_valid  (instr_valid),
      .pc           (pc),
      .pc_plus4     (pc_plus4),
      .advance      (advance),
      .pc_src       (pc_src),
      .branch_taken (branch_taken),
      .imm          (imm),
      .jalr_base    (jalr_base),
      .misalign_err (misalign_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count request handshakes seen by the memory
   always @(posedge clk) begin
      if (bus.imem_req_valid && bus.imem_req_ready) hs_cnt <= hs_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for a request, then check its address against the scoreboard
   task automatic wait_req(output logic [31:0] exp_addr);
      int n = 0;
      while (!bus.imem_req_valid && n < 50) begin
         @(posedge clk); @(negedge clk); n++;
      end
      chk("req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
      chk("sb_size", exp_q.size(), 32'd1);
      exp_addr = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      chk("req_addr", bus.imem_req_addr, exp_addr);
      $display("req  addr=%h expected=%h", bus.imem_req_addr, exp_addr);
   endtask

   // One fetch with an optional stall before ready; ends at a negedge in HOLD
   task automatic fetch(input logic [31:0] data, input int stall);
      logic [31:0] a;
      int hs0;
      wait_req(a);
      for (int i = 0; i < stall; i++) begin
         bus.imem_req_ready = 1'b0;
         @(posedge clk); @(negedge clk);
         chk("stall_valid", {31'd0, bus.imem_req_valid}, 32'd1);
         chk("stall_addr", bus.imem_req_addr, a);
      end
      hs0 = hs_cnt;
      bus.imem_req_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.imem_req_ready = 1'b0;
      chk("wait_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = data;
      @(posedge clk); @(negedge clk);
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
      chk("instr_valid", {31'd0, instr_valid}, 32'd1);
      chk("instr", instr, data);
      chk("pc", pc, a);
      chk("pc_plus4", pc_plus4, a + 32'd4);
      chk("one_handshake", hs_cnt, hs0 + 1);
      $display("fetch pc=%h instr=%h stall=%0d", pc, instr, stall);
   endtask

   // Retire the held instruction; inputs are scrambled right after the edge
   task automatic retire(input string tag, input logic [1:0] src, input logic taken,
                         input logic [31:0] imm_v, input logic [31:0] base_v,
                         input logic [31:0] exp_pc, input logic exp_err);
      advance      = 1'b1;
      pc_src       = src;
      branch_taken = taken;
      imm          = imm_v;
      jalr_base    = base_v;
      exp_q.push_back(exp_pc);
      @(posedge clk); @(negedge clk);
      advance      = 1'b0;
      pc_src       = 2'($urandom);
      branch_taken = 1'($urandom);
      imm          = $urandom;
      jalr_base    = $urandom;
      chk({tag, "_pc"}, pc, exp_pc);
      chk({tag, "_valid_drop"}, {31'd0, instr_valid}, 32'd0);
      chk({tag, "_nop"}, instr, NOP);
      chk({tag, "_err"}, {31'd0, misalign_err}, {31'd0, exp_err});
      $display("retire %s src=%b next_pc=%h err=%b", tag, src, pc, misalign_err);
   endtask

   // Asynchronous reset: values checked mid-cycle, released on the next negedge
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_state_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
      chk("rst_pc", pc, RST_PC);
      chk("rst_instr", instr, NOP);
      chk("rst_err", {31'd0, misalign_err}, 32'd0);
      $display("reset pc=%h instr=%h", pc, instr);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      exp_q.push_back(RST_PC);
   endtask

   initial begin
      logic [31:0] a;
      int          req_seen;
      rst_n              = 1'b0;
      advance            = 1'b0;
      pc_src             = 2'b00;
      branch_taken       = 1'b0;
      imm                = 32'd0;
      jalr_base          = 32'd0;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'd0;
      repeat (2) @(negedge clk);

      // 1. reset and first zero-wait fetch
      do_reset();
      @(negedge clk);
      chk("first_req_one_cycle", {31'd0, bus.imem_req_valid}, 32'd1);
      fetch(32'h0050_0093, 0);
      chk("opcode", {25'd0, instr[6:0]}, 32'h13);
      retire("seq", PC_SRC_PLUS4, 1'b0, 32'd0, 32'd0, 32'h4, 1'b0);
      fetch(32'h0040_0113, 0);

      // 2. branch taken / not taken from 0x10
      retire("jal_to10", PC_SRC_JAL, 1'b0, 32'h0000_000C, 32'd0, 32'h10, 1'b0);
      fetch(32'hFE00_0CE3, 0);
      retire("br_taken", PC_SRC_BRANCH, 1'b1, 32'hFFFF_FFF8, 32'd0, 32'h8, 1'b0);
      fetch(32'h0080_006F, 0);
      retire("jal_back", PC_SRC_JAL, 1'b0, 32'h0000_0008, 32'd0, 32'h10, 1'b0);
      fetch(32'hFE00_0CE3, 0);
      retire("br_ntaken", PC_SRC_BRANCH, 1'b0, 32'hFFFF_FFF8, 32'd0, 32'h14, 1'b0);
      fetch(32'h0000_8067, 0);

      // 3. jal and wrap-around
      retire("jalr_100", PC_SRC_JALR, 1'b0, 32'h0000_0010, 32'h0000_00F0, 32'h100, 1'b0);
      fetch(32'h0400_006F, 0);
      retire("jal_140", PC_SRC_JAL, 1'b1, 32'h0000_0040, 32'd0, 32'h140, 1'b0);
      fetch(32'h0000_8067, 0);
      retire("jalr_top", PC_SRC_JALR, 1'b0, 32'h0000_000C, 32'hFFFF_FFF0, 32'hFFFF_FFFC, 1'b0);
      fetch(32'h0000_0013, 0);
      chk("wrap_plus4", pc_plus4, 32'h0);
      retire("wrap", PC_SRC_PLUS4, 1'b1, 32'h0000_0100, 32'd0, 32'h0, 1'b0);

      // 5a. backpressure: ready low for 4 cycles
      fetch(32'h0000_8067, 4);

      // 4. jalr: aligned after clearing bit 0, then misaligned target
      retire("jalr_201", PC_SRC_JALR, 1'b0, 32'd0, 32'h0000_0201, 32'h200, 1'b0);
      fetch(32'h0000_8067, 0);
      retire("jalr_203", PC_SRC_JALR, 1'b0, 32'd0, 32'h0000_0203, 32'h202, 1'b1);
      req_seen = 0;
      advance  = 1'b1;
      bus.imem_req_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); @(negedge clk);
         if (bus.imem_req_valid) req_seen++;
      end
      advance = 1'b0;
      bus.imem_req_ready = 1'b0;
      chk("err_no_req", req_seen, 32'd0);
      chk("err_sticky", {31'd0, misalign_err}, 32'd1);
      chk("err_pc", pc, 32'h202);
      chk("err_no_valid", {31'd0, instr_valid}, 32'd0);
      do_reset();
      fetch(32'h0050_0093, 0);
      retire("post_err", PC_SRC_PLUS4, 1'b0, 32'd0, 32'd0, 32'h4, 1'b0);
      fetch(32'h0040_0113, 0);

      // 5b. reset during WAIT, stale response afterwards is ignored
      do_reset();
      wait_req(a);
      bus.imem_req_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.imem_req_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midwait_rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("midwait_rst_pc", pc, RST_PC);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      exp_q.push_back(RST_PC);
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hDEAD_BEEF;
      advance = 1'b1;
      repeat (2) begin
         @(posedge clk); @(negedge clk);
         chk("stale_valid", {31'd0, instr_valid}, 32'd0);
         chk("stale_instr", instr, NOP);
      end
      bus.imem_rsp_valid = 1'b0;
      advance = 1'b0;
      $display("stale response ignored instr=%h valid=%b", instr, instr_valid);
      fetch(32'h0010_0093, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Absolute time limit so the run always terminates
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
